// File: rtl/apb_cfg_slave.sv
// ---------------------------------------------------------------------------
// apb_cfg_slave
//   APB3/APB4 completer for a window of NUM_REGS configuration/status
//   registers, each DATA_W bits wide, starting at byte address BASE_ADDR.
//   Supports byte strobes, WAIT_CYCLES programmable wait states, read-only
//   status registers (RO_MASK) and PSLVERR on bad address, misalignment or
//   a write to a read-only register.
//
//   Handshake: a transfer is a setup cycle (psel=1, penable=0) followed by
//   one or more access cycles (psel=1, penable=1). It completes on the
//   rising edge where pready=1 in an access cycle. prdata and pslverr are
//   meaningful only while pready=1. Dropping psel during the access phase
//   abandons the transfer without any register update.
//
// Ports
//   pclk, preset        clock, asynchronous active-high reset
//   psel, penable       APB select / access-phase enable
//   pwrite, paddr       direction (1 = write) and byte address
//   pwdata, pstrb       write data and byte strobes
//   prdata, pready      read data, transfer-complete
//   pslverr             transfer error (qualified by pready)
//   reg_q               flattened register contents, reg i at [i*DATA_W +: DATA_W]
//   status_in           sources of the read-only registers
//   wr_pulse            one-cycle strobe per register after a committed write
//   state_dbg           FSM state for observation: 0 = IDLE, 1 = ACCESS
// ---------------------------------------------------------------------------
module apb_cfg_slave #(
    parameter int                      ADDR_W      = 16,
    parameter int                      DATA_W      = 16,
    parameter int                      NUM_REGS    = 8,
    parameter int                      BASE_ADDR   = 0,
    parameter int                      WAIT_CYCLES = 0,
    parameter logic [NUM_REGS-1:0]     RO_MASK     = '0
) (
    input  logic                         pclk,
    input  logic                         preset,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [ADDR_W-1:0]            paddr,
    input  logic [DATA_W-1:0]            pwdata,
    input  logic [DATA_W/8-1:0]          pstrb,
    output logic [DATA_W-1:0]            prdata,
    output logic                         pready,
    output logic                         pslverr,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    input  logic [NUM_REGS*DATA_W-1:0]   status_in,
    output logic [NUM_REGS-1:0]          wr_pulse,
    output logic                         state_dbg
);

    localparam int                NB    = DATA_W / 8;
    localparam int                SHIFT = $clog2(NB);
    localparam int                IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ALIGN = ADDR_W'(NB - 1);
    localparam logic [ADDR_W-1:0] NREG  = ADDR_W'(NUM_REGS);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t state, state_nxt;

    logic [3:0]          wcnt;
    logic [IDX_W-1:0]    idx_q;
    logic                pwrite_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [NB-1:0]       pstrb_q;
    logic                err_q;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    logic                setup, step, done, commit;

    // ---------------- address decode (setup-phase inputs) ----------------
    logic [ADDR_W-1:0]   off, idx_full;
    logic                ro_hit, dec_err;

    always_comb begin
        off      = paddr - BASE;
        idx_full = off >> SHIFT;
        ro_hit   = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_full == ADDR_W'(i) && RO_MASK[i]) ro_hit = 1'b1;
        end
        dec_err = (paddr < BASE) | (idx_full >= NREG) |
                  ((off & ALIGN) != '0) | (pwrite & ro_hit);
    end

    // ---------------- FSM ----------------
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        setup     = 1'b0;
        step      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    setup     = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    // master abandoned the transfer: nothing is committed
                    state_nxt = IDLE;
                end else if (penable) begin
                    if (wcnt != 4'd0) begin
                        step = 1'b1;
                    end else begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign commit    = done & pwrite_q & ~err_q;
    assign pready    = (state == ACCESS) && (wcnt == 4'd0);
    assign pslverr   = pready & err_q;
    assign state_dbg = (state == ACCESS);

    // ---------------- read mux ----------------
    always_comb begin
        prdata = '0;
        if (pready && !pwrite_q && !err_q) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    prdata = RO_MASK[i] ? status_in[i*DATA_W +: DATA_W] : regs[i];
                end
            end
        end
    end

    // ---------------- transfer capture and register file ----------------
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wcnt     <= '0;
            idx_q    <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            err_q    <= 1'b0;
            wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            if (setup) begin
                idx_q    <= idx_full[IDX_W-1:0];
                pwrite_q <= pwrite;
                pwdata_q <= pwdata;
                pstrb_q  <= pstrb;
                err_q    <= dec_err;
                wcnt     <= 4'(WAIT_CYCLES);
            end else if (step) begin
                wcnt <= wcnt - 4'd1;
            end

            wr_pulse <= '0;
            if (commit) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    // RO slices are never stored; they always read status_in
                    if (idx_q == IDX_W'(i) && !RO_MASK[i]) begin
                        wr_pulse[i] <= 1'b1;
                        for (int b = 0; b < NB; b++) begin
                            if (pstrb_q[b]) regs[i][8*b +: 8] <= pwdata_q[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[g*DATA_W +: DATA_W] = regs[g];
    end

    // only the RO slices of status_in are consumed; the rest is intentionally ignored
    logic status_unused;
    assign status_unused = ^status_in;

endmodule
